packet_buffer_read_arbiter: RTL and testbench

- Shares the single read port of the packet buffer RAM between two streaming requesters. The typical pair is the Ethernet TX stream_from_memory and the UART TX stream_from_memory.
- Requester 0 is the Ethernet TX requester; requester 1 is the UART TX requester.
- Each requester presents a read request and holds it until it is granted. The block forwards the granted request to the RAM.
- A latency-matched tag pipeline steers each returned word back to the requester that issued it.
- Sits between the requesters and packet_buffer_ram_driver.

---
 rtl/packet_buffer_read_arbiter.sv | 118 +++++++++++
 tb/tb_packet_buffer_read_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_buffer_read_arbiter.sv
// Round-robin arbiter sharing the packet buffer RAM read port between two requesters,
// with a latency-matched tag pipeline steering read data back. Define ARB_LOCK_EN for burst lock.
module packet_buffer_read_arbiter #(
  parameter int RAM_SIZE         = 256,
  parameter int WORD_LEN         = 8,
  parameter int RAM_READ_LATENCY = 2,
  localparam int AW              = $clog2(RAM_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_readclk,
  input  logic [AW-1:0]       req0_raddr,
  input  logic                req0_lock,
  output logic                req0_gnt,
  output logic                req0_outclk,
  output logic [WORD_LEN-1:0] req0_out,
  input  logic                req1_readclk,
  input  logic [AW-1:0]       req1_raddr,
  input  logic                req1_lock,
  output logic                req1_gnt,
  output logic                req1_outclk,
  output logic [WORD_LEN-1:0] req1_out,
  output logic                ram_readclk,
  output logic [AW-1:0]       ram_raddr,
  input  logic                ram_outclk,
  input  logic [WORD_LEN-1:0] ram_out,
  output logic                err
);
  localparam int L  = RAM_READ_LATENCY;
  localparam int BW = $clog2(L + 1);

  logic          last_gnt;
  logic          err_q;
  logic [L-1:0]  tag_v;
  logic [L-1:0]  tag_id;
  logic [BW-1:0] blank_cnt;
  logic          elig0;
  logic          elig1;
  logic          exit_v;
  logic          exit_id;

`ifdef ARB_LOCK_EN
  logic lock_act;
  logic lock_id;
  logic lock_hold;

  // The owner keeps the port while its lock is high, even when it is not requesting.
  assign lock_hold = lock_act && (lock_id ? req1_lock : req0_lock);
  assign elig0     = req0_readclk && !(lock_hold && lock_id);
  assign elig1     = req1_readclk && !(lock_hold && !lock_id);

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_act <= 1'b0;
      lock_id  <= 1'b0;
    end else if ((req0_gnt && req0_lock) || (req1_gnt && req1_lock)) begin
      lock_act <= 1'b1;
      lock_id  <= req1_gnt;
    end else if (lock_act && !(lock_id ? req1_lock : req0_lock)) begin
      lock_act <= 1'b0;
    end
  end
`else
  logic unused_lock;

  assign unused_lock = req0_lock ^ req1_lock;
  assign elig0       = req0_readclk;
  assign elig1       = req1_readclk;
`endif

  always_comb begin
    req0_gnt = 1'b0;
    req1_gnt = 1'b0;
    if (!rst) begin
      if (elig0 && elig1) begin
        req0_gnt = last_gnt;
        req1_gnt = !last_gnt;
      end else begin
        req0_gnt = elig0;
        req1_gnt = elig1;
      end
    end
  end

  assign ram_readclk = req0_gnt | req1_gnt;
  // With no grant the select stays on the last winner, so the address bus does not toggle.
  assign ram_raddr   = rst ? '0 :
                       (req1_gnt || (!req0_gnt && last_gnt)) ? req1_raddr : req0_raddr;

  assign exit_v      = tag_v[L-1];
  assign exit_id     = tag_id[L-1];
  assign req0_outclk = !rst && ram_outclk && exit_v && !exit_id;
  assign req1_outclk = !rst && ram_outclk && exit_v && exit_id;
  assign req0_out    = ram_out;
  assign req1_out    = ram_out;
  assign err         = err_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt  <= 1'b1;
      tag_v     <= '0;
      tag_id    <= '0;
      err_q     <= 1'b0;
      blank_cnt <= BW'(L);
    end else begin
      if (ram_readclk) last_gnt <= req1_gnt;
      for (int i = L - 1; i > 0; i--) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      tag_v[0]  <= ram_readclk;
      tag_id[0] <= req1_gnt;
      // Reads issued before reset may still return; ignore them for one latency window.
      if (blank_cnt != '0) blank_cnt <= blank_cnt - BW'(1);
      else if (ram_outclk != exit_v) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_packet_buffer_read_arbiter.sv
// Bench for packet_buffer_read_arbiter: RAM model, scoreboard reference, vector table,
// directed corner sequences and randomized requester traffic.
module tb_packet_buffer_read_arbiter;
  localparam int RAM_SIZE = 256;
  localparam int WORD_LEN = 8;
  localparam int L        = 2;
  localparam int AW       = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                req0_readclk, req0_lock, req0_gnt, req0_outclk;
  logic [AW-1:0]       req0_raddr;
  logic [WORD_LEN-1:0] req0_out;
  logic                req1_readclk, req1_lock, req1_gnt, req1_outclk;
  logic [AW-1:0]       req1_raddr;
  logic [WORD_LEN-1:0] req1_out;
  logic                ram_readclk, ram_outclk, err;
  logic [AW-1:0]       ram_raddr;
  logic [WORD_LEN-1:0] ram_out;

  packet_buffer_read_arbiter #(
    .RAM_SIZE(RAM_SIZE), .WORD_LEN(WORD_LEN), .RAM_READ_LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_readclk(req0_readclk), .req0_raddr(req0_raddr), .req0_lock(req0_lock),
    .req0_gnt(req0_gnt), .req0_outclk(req0_outclk), .req0_out(req0_out),
    .req1_readclk(req1_readclk), .req1_raddr(req1_raddr), .req1_lock(req1_lock),
    .req1_gnt(req1_gnt), .req1_outclk(req1_outclk), .req1_out(req1_out),
    .ram_readclk(ram_readclk), .ram_raddr(ram_raddr),
    .ram_outclk(ram_outclk), .ram_out(ram_out), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_oc0 = 0;
  int n_oc1 = 0;

  // RAM model pipeline
  logic          pipe_v[L];
  logic [AW-1:0] pipe_a[L];

  // Reference model state
  typedef struct {
    int             due;
    int             id;
    logic [WORD_LEN-1:0] data;
  } resp_t;
  resp_t q[$];
  int    m_last  = 1;
  int    m_owner = -1;
  logic  m_err   = 1'b0;
  int    m_blank = 0;

  typedef struct {
    logic          v0;
    logic [AW-1:0] a0;
    logic          v1;
    logic [AW-1:0] a1;
    logic          e0;
    logic          e1;
    logic [AW-1:0] ea;
  } vec_t;
  vec_t tbl[12];

  logic          g0, g1;
  logic [AW-1:0] ra;

  function automatic logic [WORD_LEN-1:0] mem_word(input logic [AW-1:0] a);
    return a * 8'd37 + 8'd11;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic run_cycle(input logic r, input logic v0, input logic [AW-1:0] a0, input logic l0,
                           input logic v1, input logic [AW-1:0] a1, input logic l1,
                           input logic stray, output logic og0, output logic og1,
                           output logic [AW-1:0] ora);
    int            win;
    logic          due;
    int            due_id;
    logic          e_elig0, e_elig1, exp_oc0, exp_oc1, rd_v;
    logic [AW-1:0] rd_a;
    rst          = r;
    req0_readclk = v0; req0_raddr = a0; req0_lock = l0;
    req1_readclk = v1; req1_raddr = a1; req1_lock = l1;
    ram_outclk   = pipe_v[L-1] | stray;
    ram_out      = pipe_v[L-1] ? mem_word(pipe_a[L-1]) : 8'hEE;
    @(negedge clk);
    e_elig0 = v0;
    e_elig1 = v1;
`ifdef ARB_LOCK_EN
    if (m_owner == 0 && l0) e_elig1 = 1'b0;
    if (m_owner == 1 && l1) e_elig0 = 1'b0;
`endif
    win = -1;
    if (!r) begin
      if (e_elig0 && e_elig1) win = 1 - m_last;
      else if (e_elig0) win = 0;
      else if (e_elig1) win = 1;
    end
    due     = (q.size() > 0) && (q[0].due == cyc);
    due_id  = due ? q[0].id : -1;
    exp_oc0 = !r && ram_outclk && due && due_id == 0;
    exp_oc1 = !r && ram_outclk && due && due_id == 1;
    check("gnt0", 32'(req0_gnt), 32'(win == 0));
    check("gnt1", 32'(req1_gnt), 32'(win == 1));
    check("ram_readclk", 32'(ram_readclk), 32'(win >= 0));
    if (win >= 0) check("ram_raddr", 32'(ram_raddr), 32'(win == 0 ? a0 : a1));
    check("outclk0", 32'(req0_outclk), 32'(exp_oc0));
    check("outclk1", 32'(req1_outclk), 32'(exp_oc1));
    if (exp_oc0) check("out0", 32'(req0_out), 32'(q[0].data));
    if (exp_oc1) check("out1", 32'(req1_out), 32'(q[0].data));
    check("err", 32'(err), 32'(r ? 1'b0 : m_err));
    if (req0_outclk) n_oc0++;
    if (req1_outclk) n_oc1++;
    og0  = req0_gnt;
    og1  = req1_gnt;
    ora  = ram_raddr;
    rd_v = ram_readclk;
    rd_a = ram_raddr;
    if (r) begin
      m_last = 1; m_owner = -1; m_err = 1'b0; m_blank = L;
      q.delete();
    end else begin
      if (due) q.delete(0);
      if (m_blank > 0) m_blank--;
      else if (ram_outclk != due) m_err = 1'b1;
      if (win >= 0) begin
        q.push_back('{due: cyc + L, id: win, data: mem_word(win == 0 ? a0 : a1)});
        m_last = win;
      end
`ifdef ARB_LOCK_EN
      if (win >= 0 && (win == 0 ? l0 : l1)) m_owner = win;
      else if (m_owner >= 0 && !(m_owner == 0 ? l0 : l1)) m_owner = -1;
`endif
    end
    cyc++;
    @(posedge clk);
    #1;
    for (int i = L - 1; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_a[i] = pipe_a[i-1];
    end
    pipe_v[0] = rd_v;
    pipe_a[0] = rd_a;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(0, 0, '0, 0, 0, '0, 0, 0, g0, g1, ra);
  endtask

  initial begin
    int            cnt, used, first1, base0, base1, n1;
    logic          act0, act1, lk0, lk1, e0;
    logic [AW-1:0] adr0, adr1, a;
    for (int i = 0; i < L; i++) begin
      pipe_v[i] = 1'b0;
      pipe_a[i] = '0;
    end
    tbl[0]  = '{1'b1, 8'd5,  1'b1, 8'd9,  1'b1, 1'b0, 8'd5};
    tbl[1]  = '{1'b1, 8'd5,  1'b1, 8'd9,  1'b0, 1'b1, 8'd9};
    tbl[2]  = '{1'b1, 8'd5,  1'b1, 8'd9,  1'b1, 1'b0, 8'd5};
    tbl[3]  = '{1'b1, 8'd5,  1'b1, 8'd9,  1'b0, 1'b1, 8'd9};
    tbl[4]  = '{1'b0, 8'd0,  1'b1, 8'd9,  1'b0, 1'b1, 8'd9};
    tbl[5]  = '{1'b0, 8'd0,  1'b1, 8'd10, 1'b0, 1'b1, 8'd10};
    tbl[6]  = '{1'b1, 8'd3,  1'b1, 8'd10, 1'b1, 1'b0, 8'd3};
    tbl[7]  = '{1'b0, 8'd0,  1'b1, 8'd10, 1'b0, 1'b1, 8'd10};
    tbl[8]  = '{1'b0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0, 8'd0};
    tbl[9]  = '{1'b1, 8'd7,  1'b0, 8'd0,  1'b1, 1'b0, 8'd7};
    tbl[10] = '{1'b1, 8'd7,  1'b1, 8'd2,  1'b0, 1'b1, 8'd2};
    tbl[11] = '{1'b1, 8'd7,  1'b0, 8'd0,  1'b1, 1'b0, 8'd7};

    // reset, then tie-after-reset and round-robin table
    run_cycle(1, 1, 8'd5, 0, 1, 8'd9, 0, 0, g0, g1, ra);
    run_cycle(1, 0, '0, 0, 0, '0, 0, 0, g0, g1, ra);
    for (int i = 0; i < 12; i++) begin
      run_cycle(0, tbl[i].v0, tbl[i].a0, 0, tbl[i].v1, tbl[i].a1, 0, 0, g0, g1, ra);
      check($sformatf("tbl%0d_gnt0", i), 32'(g0), 32'(tbl[i].e0));
      check($sformatf("tbl%0d_gnt1", i), 32'(g1), 32'(tbl[i].e1));
      if (tbl[i].e0 || tbl[i].e1) check($sformatf("tbl%0d_raddr", i), 32'(ra), 32'(tbl[i].ea));
    end
    idle(4);

    // single-requester burst: four back-to-back grants and responses
    base0 = n_oc0; base1 = n_oc1;
    cnt = 0; used = 0; a = '0;
    while (cnt < 4 && used < 10) begin
      run_cycle(0, 1, a, 0, 0, '0, 0, 0, g0, g1, ra);
      used++;
      if (g0) begin cnt++; a++; end
    end
    check("burst_cycles", 32'(used), 32'd4);
    idle(4);
    check("burst_oc0", 32'(n_oc0 - base0), 32'd4);
    check("burst_oc1", 32'(n_oc1 - base1), 32'd0);

    // held request: req1 contends with a 3-word req0 burst
    cnt = 0; used = 0; first1 = -1; a = 8'd20; n1 = 0;
    while ((cnt < 3 || first1 < 0) && used < 12) begin
      run_cycle(0, cnt < 3, a, 0, first1 < 0, 8'd40, 0, 0, g0, g1, ra);
      if (g1 && first1 < 0) first1 = used;
      if (g0) begin cnt++; a++; end
      used++;
    end
    check("held_gnt1_by_2nd", 32'(first1 >= 0 && first1 <= 1), 32'd1);
    idle(4);

    // stray response sets sticky err; reset clears it
    base0 = n_oc0; base1 = n_oc1;
    run_cycle(0, 0, '0, 0, 0, '0, 0, 1, g0, g1, ra);
    check("stray_err_set", 32'(err), 32'd1);
    idle(3);
    check("stray_err_sticky", 32'(err), 32'd1);
    check("stray_no_oc", 32'((n_oc0 - base0) + (n_oc1 - base1)), 32'd0);
    run_cycle(1, 0, '0, 0, 0, '0, 0, 0, g0, g1, ra);
    check("stray_err_clr", 32'(err), 32'd0);
    idle(4);

    // reset one cycle after a grant: the read is dropped silently
    base0 = n_oc0; base1 = n_oc1;
    run_cycle(0, 1, 8'd77, 0, 0, '0, 0, 0, g0, g1, ra);
    run_cycle(1, 0, '0, 0, 0, '0, 0, 0, g0, g1, ra);
    idle(4);
    check("rstmid_no_oc", 32'((n_oc0 - base0) + (n_oc1 - base1)), 32'd0);
    check("rstmid_err", 32'(err), 32'd0);
    run_cycle(0, 1, 8'd1, 0, 1, 8'd2, 0, 0, g0, g1, ra);
    check("rstmid_tie_gnt0", 32'(g0), 32'd1);
    idle(4);

    // burst lock: req0 locks a 4-word burst while req1 requests throughout
    run_cycle(1, 0, '0, 0, 0, '0, 0, 0, g0, g1, ra);
    idle(3);
    cnt = 0; n1 = 0;
    for (int i = 0; i < 8; i++) begin
      run_cycle(0, cnt < 4, AW'(100 + cnt), cnt < 4, 1, AW'(200 + n1), 0, 0, g0, g1, ra);
`ifdef ARB_LOCK_EN
      e0 = (i < 4);
`else
      e0 = (i % 2 == 0);
`endif
      check($sformatf("lock%0d_gnt0", i), 32'(g0), 32'(e0));
      check($sformatf("lock%0d_gnt1", i), 32'(g1), 32'(!e0));
      if (g0) cnt++;
      if (g1) n1++;
    end
    idle(4);

    // randomized requester traffic against the reference model
    act0 = 0; act1 = 0; lk0 = 0; lk1 = 0; adr0 = '0; adr1 = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!act0 && ($urandom % 2 == 0)) begin
        act0 = 1; adr0 = AW'($urandom); lk0 = ($urandom % 4 == 0);
      end
      if (!act1 && ($urandom % 2 == 0)) begin
        act1 = 1; adr1 = AW'($urandom); lk1 = ($urandom % 4 == 0);
      end
      run_cycle($urandom % 250 == 0, act0, adr0, act0 & lk0, act1, adr1, act1 & lk1, 0,
                g0, g1, ra);
      if (g0) begin
        if ($urandom % 2 == 0) adr0 = AW'($urandom);
        else act0 = 0;
      end
      if (g1) begin
        if ($urandom % 2 == 0) adr1 = AW'($urandom);
        else act1 = 0;
      end
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
